// File: rtl/reg_bus_arbiter_if.sv
// Signal bundle between the two requesters, the arbiter and the register-file bus.
interface reg_bus_arbiter_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
);
  logic                  a_req, a_wr, a_ack;
  logic [1:0]            a_be;
  logic [ADDR_WIDTH-1:0] a_addr;
  logic [DATA_WIDTH-1:0] a_wdata, a_rdata;

  logic                  b_req, b_wr, b_ack;
  logic [1:0]            b_be;
  logic [ADDR_WIDTH-1:0] b_addr;
  logic [DATA_WIDTH-1:0] b_wdata, b_rdata;

  logic                  bus_en, bus_rd, bus_wr, bus_wdata_oe;
  logic [1:0]            bus_be;
  logic [ADDR_WIDTH-1:0] bus_addr;
  logic [DATA_WIDTH-1:0] bus_wdata, bus_rdata;

  // The arbiter is the slave of both requesters and drives the register-file bus.
  modport slave (
    input  a_req, a_wr, a_be, a_addr, a_wdata,
    output a_ack, a_rdata,
    input  b_req, b_wr, b_be, b_addr, b_wdata,
    output b_ack, b_rdata,
    output bus_en, bus_rd, bus_wr, bus_wdata_oe, bus_be, bus_addr, bus_wdata,
    input  bus_rdata
  );

  modport master (
    output a_req, a_wr, a_be, a_addr, a_wdata,
    input  a_ack, a_rdata,
    output b_req, b_wr, b_be, b_addr, b_wdata,
    input  b_ack, b_rdata,
    input  bus_en, bus_rd, bus_wr, bus_wdata_oe, bus_be, bus_addr, bus_wdata,
    output bus_rdata
  );
endinterface

// File: rtl/reg_bus_arbiter.sv
// Round-robin arbiter for two requesters sharing the register-file async bus;
// sequences en/rd/wr strobes so writes latch on the falling edge of wr.
module reg_bus_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int RD_WAIT    = 2
) (
  input logic              clk,
  input logic              reset,
  reg_bus_arbiter_if.slave bus
);
  localparam int CNT_W = (RD_WAIT > 1) ? $clog2(RD_WAIT) : 1;

  typedef enum logic [2:0] {IDLE, W_SETUP, W_STROBE, W_HOLD, R_STROBE, R_TURN} state_t;

  state_t                state;
  logic                  prefer_b;
  logic                  gnt_b;
  logic [CNT_W-1:0]      wait_cnt;

  logic                  pick_any, pick_b, sel_wr;
  logic [1:0]            sel_be;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  // B wins when it is the only requester or when A was the port served last.
  always_comb begin
    pick_any  = bus.a_req | bus.b_req;
    pick_b    = bus.b_req & (~bus.a_req | prefer_b);
    sel_wr    = pick_b ? bus.b_wr    : bus.a_wr;
    sel_be    = pick_b ? bus.b_be    : bus.a_be;
    sel_addr  = pick_b ? bus.b_addr  : bus.a_addr;
    sel_wdata = pick_b ? bus.b_wdata : bus.a_wdata;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state            <= IDLE;
      prefer_b         <= 1'b0;
      gnt_b            <= 1'b0;
      wait_cnt         <= '0;
      bus.bus_en       <= 1'b0;
      bus.bus_rd       <= 1'b0;
      bus.bus_wr       <= 1'b0;
      bus.bus_wdata_oe <= 1'b0;
      bus.bus_be       <= '0;
      bus.bus_addr     <= '0;
      bus.bus_wdata    <= '0;
      bus.a_ack        <= 1'b0;
      bus.b_ack        <= 1'b0;
      bus.a_rdata      <= '0;
      bus.b_rdata      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            gnt_b        <= pick_b;
            prefer_b     <= ~pick_b;
            bus.bus_en   <= 1'b1;
            bus.bus_be   <= sel_be;
            bus.bus_addr <= sel_addr;
            if (sel_wr) begin
              bus.bus_wdata    <= sel_wdata;
              bus.bus_wdata_oe <= 1'b1;
              state            <= W_SETUP;
            end else begin
              bus.bus_rd <= 1'b1;
              wait_cnt   <= CNT_W'(RD_WAIT - 1);
              state      <= R_STROBE;
            end
          end
        end
        W_SETUP: begin
          bus.bus_wr <= 1'b1;
          state      <= W_STROBE;
        end
        W_STROBE: begin
          bus.bus_wr <= 1'b0;
          bus.a_ack  <= ~gnt_b;
          bus.b_ack  <= gnt_b;
          state      <= W_HOLD;
        end
        W_HOLD: begin
          bus.bus_en       <= 1'b0;
          bus.bus_wdata_oe <= 1'b0;
          bus.bus_be       <= '0;
          bus.bus_addr     <= '0;
          bus.bus_wdata    <= '0;
          bus.a_ack        <= 1'b0;
          bus.b_ack        <= 1'b0;
          state            <= IDLE;
        end
        R_STROBE: begin
          if (wait_cnt == '0) begin
            if (gnt_b) bus.b_rdata <= bus.bus_rdata;
            else       bus.a_rdata <= bus.bus_rdata;
            bus.bus_en <= 1'b0;
            bus.bus_rd <= 1'b0;
            bus.a_ack  <= ~gnt_b;
            bus.b_ack  <= gnt_b;
            state      <= R_TURN;
          end else begin
            wait_cnt <= wait_cnt - CNT_W'(1);
          end
        end
        R_TURN: begin
          bus.bus_be   <= '0;
          bus.bus_addr <= '0;
          bus.a_ack    <= 1'b0;
          bus.b_ack    <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Scoreboard bench for reg_bus_arbiter: directed requests push expected results,
// a negedge monitor checks bus timing, ack order and read data.
module tb_reg_bus_arbiter;
  localparam int AW      = 16;
  localparam int DW      = 16;
  localparam int RD_WAIT = 2;

  typedef struct {
    bit            port_b;
    bit            wr;
    logic [1:0]    be;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  bit   mon_en   = 1'b0;
  exp_t sb[$];

  logic [DW-1:0] mem [0:15];

  reg_bus_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bif();

  reg_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_WAIT(RD_WAIT)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bif)
  );

  always #5 clk = ~clk;

  // Register-file model: byte writes latch on the falling edge of wr.
  initial for (int i = 0; i < 16; i++) mem[i] = '0;
  always @(negedge bif.bus_wr) begin
    if (bif.bus_en === 1'b1 && bif.bus_rd === 1'b0) begin
      if (bif.bus_be[0]) mem[bif.bus_addr[3:0]][7:0]  <= bif.bus_wdata[7:0];
      if (bif.bus_be[1]) mem[bif.bus_addr[3:0]][15:8] <= bif.bus_wdata[15:8];
    end
  end
  assign bif.bus_rdata = (bif.bus_en && bif.bus_rd) ? mem[bif.bus_addr[3:0]] : '0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic void expect_txn(bit port_b, bit wr, logic [1:0] be, logic [AW-1:0] addr,
                                     logic [DW-1:0] wdata, logic [DW-1:0] rdata);
    exp_t e;
    e.port_b = port_b;
    e.wr     = wr;
    e.be     = be;
    e.addr   = addr;
    e.wdata  = wdata;
    e.rdata  = rdata;
    sb.push_back(e);
  endfunction

  task automatic applyStimulus(input bit port_b, input bit wr, input logic [1:0] be,
                               input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                               input bit drop);
    bit seen = 1'b0;
    if (port_b) begin
      bif.b_wr = wr; bif.b_be = be; bif.b_addr = addr; bif.b_wdata = wdata; bif.b_req = 1'b1;
    end else begin
      bif.a_wr = wr; bif.a_be = be; bif.a_addr = addr; bif.a_wdata = wdata; bif.a_req = 1'b1;
    end
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk); #1;
      seen = port_b ? bif.b_ack : bif.a_ack;
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("[TB] FAIL ack_timeout port_b=%0d: got no ack, want ack within 40 cycles", port_b);
    end
    if (drop || !seen) begin
      if (port_b) bif.b_req = 1'b0;
      else        bif.a_req = 1'b0;
    end
  endtask

  // Monitor: every transaction starts with bus_en rising and ends with one ack.
  exp_t          cur;
  bit            active = 1'b0;
  bit            prev_rd = 1'b0;
  bit            just_acked = 1'b0;
  int            t = 0;
  logic [DW-1:0] exp_a_rdata = '0;
  logic [DW-1:0] exp_b_rdata = '0;

  initial forever begin
    @(negedge clk);
    if (!reset) begin
      active = 1'b0; just_acked = 1'b0; prev_rd = 1'b0;
      exp_a_rdata = '0; exp_b_rdata = '0;
    end else if (mon_en) begin
      checkOutput("rd_wr_overlap", bif.bus_rd & bif.bus_wr, 0);
      checkOutput("oe_during_rd", bif.bus_rd & bif.bus_wdata_oe, 0);
      checkOutput("oe_after_rd", prev_rd & ~bif.bus_rd & bif.bus_wdata_oe, 0);
      checkOutput("wr_without_en", bif.bus_wr & ~bif.bus_en, 0);
      checkOutput("dual_ack", bif.a_ack & bif.b_ack, 0);
      if (!active && bif.bus_en) begin
        checkOutput("idle_gap", just_acked, 0);
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_txn: got bus_en=1 addr=0x%0h, want no transaction", bif.bus_addr);
        end else begin
          cur    = sb[0];
          active = 1'b1;
          t      = 0;
          checkOutput("grant_addr", bif.bus_addr, cur.addr);
          checkOutput("grant_be", bif.bus_be, cur.be);
          if (cur.wr) checkOutput("grant_wdata", bif.bus_wdata, cur.wdata);
        end
      end
      just_acked = 1'b0;
      if (active) begin
        t++;
        if (cur.wr) begin
          if (t <= 3) begin
            checkOutput("w_en", bif.bus_en, 1);
            checkOutput("w_oe", bif.bus_wdata_oe, 1);
            checkOutput("w_strobe", bif.bus_wr, (t == 2));
          end
        end else begin
          checkOutput("r_rd", bif.bus_rd, (t <= RD_WAIT));
          checkOutput("r_en", bif.bus_en, (t <= RD_WAIT));
          checkOutput("r_oe", bif.bus_wdata_oe, 0);
        end
        if (bif.a_ack || bif.b_ack) begin
          checkOutput("ack_port", bif.b_ack, cur.port_b);
          checkOutput("ack_latency", t, cur.wr ? 3 : RD_WAIT + 1);
          if (!cur.wr) begin
            if (cur.port_b) exp_b_rdata = cur.rdata;
            else            exp_a_rdata = cur.rdata;
          end
          checkOutput("a_rdata", bif.a_rdata, exp_a_rdata);
          checkOutput("b_rdata", bif.b_rdata, exp_b_rdata);
          void'(sb.pop_front());
          active     = 1'b0;
          just_acked = 1'b1;
        end else if (t > RD_WAIT + 4) begin
          checks++;
          failures++;
          $display("[TB] FAIL txn_stuck addr=0x%0h: got no ack after %0d cycles, want ack", cur.addr, t);
          void'(sb.pop_front());
          active = 1'b0;
        end
      end else if (!bif.bus_en) begin
        checkOutput("idle_strobes", {bif.bus_rd, bif.bus_wr, bif.bus_wdata_oe, bif.bus_be}, 0);
        checkOutput("idle_addr", bif.bus_addr, 0);
        checkOutput("stray_ack", bif.a_ack | bif.b_ack, 0);
      end
      prev_rd = bif.bus_rd;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no end of test, want end within 200000 time units");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit found;
    bit quiet_bad;
    bif.a_req = 1'b0; bif.a_wr = 1'b0; bif.a_be = '0; bif.a_addr = '0; bif.a_wdata = '0;
    bif.b_req = 1'b0; bif.b_wr = 1'b0; bif.b_be = '0; bif.b_addr = '0; bif.b_wdata = '0;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_strobes", {bif.bus_en, bif.bus_rd, bif.bus_wr, bif.bus_wdata_oe, bif.a_ack, bif.b_ack}, 0);
    checkOutput("rst_addr", bif.bus_addr, 0);
    checkOutput("rst_wdata", bif.bus_wdata, 0);
    checkOutput("rst_be", bif.bus_be, 0);
    checkOutput("rst_a_rdata", bif.a_rdata, 0);
    checkOutput("rst_b_rdata", bif.b_rdata, 0);
    reset  = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);

    // Both ports at once after reset: A first, then B reads A's data back.
    expect_txn(0, 1, 2'b11, 16'h0003, 16'hBEEF, 16'h0000);
    expect_txn(1, 0, 2'b11, 16'h0003, 16'h0000, 16'hBEEF);
    fork
      applyStimulus(0, 1, 2'b11, 16'h0003, 16'hBEEF, 1);
      applyStimulus(1, 0, 2'b11, 16'h0003, 16'h0000, 1);
    join
    @(negedge clk);

    // Continuous contention: grants must alternate A,B,A,B,A,B.
    expect_txn(0, 1, 2'b11, 16'h0001, 16'h1111, 16'h0000);
    expect_txn(1, 0, 2'b11, 16'h0001, 16'h0000, 16'h1111);
    expect_txn(0, 0, 2'b11, 16'h0003, 16'h0000, 16'hBEEF);
    expect_txn(1, 1, 2'b11, 16'h0004, 16'h4444, 16'h0000);
    expect_txn(0, 1, 2'b11, 16'h0002, 16'h2222, 16'h0000);
    expect_txn(1, 0, 2'b11, 16'h0004, 16'h0000, 16'h4444);
    fork
      begin
        applyStimulus(0, 1, 2'b11, 16'h0001, 16'h1111, 0);
        applyStimulus(0, 0, 2'b11, 16'h0003, 16'h0000, 0);
        applyStimulus(0, 1, 2'b11, 16'h0002, 16'h2222, 1);
      end
      begin
        applyStimulus(1, 0, 2'b11, 16'h0001, 16'h0000, 0);
        applyStimulus(1, 1, 2'b11, 16'h0004, 16'h4444, 0);
        applyStimulus(1, 0, 2'b11, 16'h0004, 16'h0000, 1);
      end
    join
    @(negedge clk);

    // Byte enables: low byte only, then no bytes at all.
    expect_txn(0, 1, 2'b01, 16'h0003, 16'h1234, 16'h0000);
    applyStimulus(0, 1, 2'b01, 16'h0003, 16'h1234, 1);
    expect_txn(1, 0, 2'b11, 16'h0003, 16'h0000, 16'hBE34);
    applyStimulus(1, 0, 2'b11, 16'h0003, 16'h0000, 1);
    expect_txn(0, 1, 2'b00, 16'h0003, 16'hFFFF, 16'h0000);
    applyStimulus(0, 1, 2'b00, 16'h0003, 16'hFFFF, 1);
    expect_txn(0, 0, 2'b11, 16'h0003, 16'h0000, 16'hBE34);
    applyStimulus(0, 0, 2'b11, 16'h0003, 16'h0000, 1);

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    checkOutput("sb_drained", sb.size(), 0);
    @(negedge clk);

    // Reset during W_STROBE aborts the write without an ack.
    mon_en = 1'b0;
    bif.a_wr = 1'b1; bif.a_be = 2'b11; bif.a_addr = 16'h0005; bif.a_wdata = 16'hDEAD;
    bif.a_req = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge clk); #1;
      found = bif.bus_wr;
    end
    checkOutput("abort_reach_strobe", found, 1);
    reset     = 1'b0;
    bif.a_req = 1'b0;
    @(posedge clk); #1;
    checkOutput("abort_wr", bif.bus_wr, 0);
    checkOutput("abort_en", bif.bus_en, 0);
    checkOutput("abort_oe", bif.bus_wdata_oe, 0);
    checkOutput("abort_ack", bif.a_ack | bif.b_ack, 0);
    checkOutput("abort_a_rdata", bif.a_rdata, 0);
    @(negedge clk);
    reset = 1'b1;
    quiet_bad = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      quiet_bad = quiet_bad | bif.a_ack | bif.b_ack | bif.bus_en;
    end
    checkOutput("abort_quiet", quiet_bad, 0);
    @(negedge clk);
    mon_en = 1'b1;

    // After reset the pointer favours A again.
    expect_txn(0, 1, 2'b11, 16'h0006, 16'h5A5A, 16'h0000);
    expect_txn(1, 0, 2'b11, 16'h0003, 16'h0000, 16'hBE34);
    fork
      applyStimulus(0, 1, 2'b11, 16'h0006, 16'h5A5A, 1);
      applyStimulus(1, 0, 2'b11, 16'h0003, 16'h0000, 1);
    join

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    checkOutput("sb_drained_end", sb.size(), 0);
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
